shift_tx_ctrl: RTL and testbench
================================

# shift_tx_ctrl

Sequencing controller that sits directly upstream of the 16-bit Load/Shift `Register` and turns it into a parallel-in, serial-out transmitter. It accepts a parallel word over a valid/ready handshake and pulses `Load` once to capture the word. It then pulses `Shift` once per serial bit consumed downstream, taking the serial bit from the register's MSB. When the frame ends it reports completion and can start the next word back-to-back with no idle cycle.

## Interface
- `N`, 16: word width in bits; must equal the downstream `Register` width; N ≥ 2.
- `FILL`, 1'b0: constant driven on `Shift_In` (the value shifted into the register LSB).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset; `reset==0` at a rising edge clears all state.
- `in_valid`  in  1  upstream word available.
- `in_data`  in  N  upstream word, MSB transmitted first.
- `in_ready`  out  1  controller can accept a word this cycle.
- `bit_stall`  in  1  downstream not consuming the current serial bit.
- `bit_valid`  out  1  the register's `Dout[N-1]` holds a valid serial bit this cycle.
- `Load`  out  1  to `Register.Load`.
- `Shift`  out  1  to `Register.Shift`.
- `Din`  out  N  to `Register.Din`; equals `in_data` (combinational pass-through).
- `Shift_In`  out  1  to `Register.Shift_In`; constant `FILL`.
- `bit_idx`  out  $clog2(N)  index of the current bit within the frame, 0 = MSB.
- `done`  out  1  one-cycle pulse on the cycle the last bit of a frame is consumed.

## Operation
- States: IDLE and SEND. The bit counter `cnt` is $clog2(N) bits wide and `bit_idx = cnt`.
- Accept condition: `acc = in_valid & in_ready`. On `acc`, `Load=1` for that cycle, so the register captures `in_data` at the same clock edge.
- IDLE:
  - `in_ready=1`, `bit_valid=0`, `Shift=0`.
  - On `acc`: go to SEND with `cnt=0`.
- SEND:
  - `bit_valid=1`.
  - A bit is consumed when `bit_valid & ~bit_stall`.
  - For a non-last bit (`cnt<N-1`), consuming it sets `Shift=1` and `cnt` increments.
  - For the last bit (`cnt==N-1`), consuming it pulses `done=1`.
  - On the last-bit consume, `in_ready=1`:
    - If `in_valid=1`, then `Load=1` and `Shift=0`. State stays SEND with `cnt=0`. This is back-to-back operation with no bubble.
    - Otherwise `Shift=0` and the state goes to IDLE. The register keeps its content, which is don't-care.
  - `in_ready=0` in every other SEND cycle.
- `Load` and `Shift` are never asserted together.
- `bit_stall=1` freezes the controller: `Shift=0` and `cnt` holds. The register holds the same bit indefinitely.
- `bit_stall` is ignored in IDLE.
- `in_data` is sampled only on the `acc` cycle. Changes at any other time have no effect.

## Timing
- Reset (`reset==0` at an edge):
  - Next-cycle state: state=IDLE, `cnt=0`.
  - Output values: `in_ready=1`, `bit_valid=0`, `Load=0`, `Shift=0`, `done=0`, `bit_idx=0`.
- Reset in mid-frame aborts the frame:
  - No `done` pulse is issued.
  - A word whose `acc` coincides with the reset edge is dropped.
- All outputs are functions of registered state plus the same-cycle `in_valid`/`bit_stall`. The controller has no registered output delay.
- Latency:
  - `acc` at cycle t puts MSB `in_data[N-1]` on `Dout[N-1]` with `bit_valid=1` at t+1.
  - Bit k appears at t+1+k when there are no stalls.
  - A frame occupies exactly N SEND cycles plus the number of stall cycles.
- Throughput: one N-bit word per N cycles when `in_valid` is held high and `bit_stall=0`.
- `done` asserts in the same cycle as the last bit's `bit_valid` and is never asserted in IDLE.

## Test plan
- Single word: N=16, `in_data=16'hA5C3`, no stall. Required response:
  - `Load` pulse at t.
  - `bit_valid` high t+1..t+16.
  - Serial MSB-first stream = 1010_0101_1100_0011.
  - 15 `Shift` pulses.
  - `done` at t+16.
  - IDLE at t+17.
- Back-to-back: words 16'hFFFF then 16'h0001 with `in_valid` held high. Required response:
  - Second `Load` coincides with the first word's `done` cycle.
  - 32 contiguous `bit_valid` cycles.
  - Final 16 bits = 0…01.
- Stall: N=4, `in_data=4'b1001`, `bit_stall=1` on bit_idx=2 for 3 cycles. Required response:
  - `bit_idx` holds at 2 and `Dout[3]` holds 0 for 4 cycles, with `Shift=0` during the stall.
  - `done` at t+7.
- Reset mid-frame: `reset=0` while bit_idx=5. Required response:
  - Next cycle IDLE, `in_ready=1`.
  - No `done` pulse.
  - A following word transmits correctly from its MSB.
- Handshake: `in_valid` pulsed during SEND at bit_idx<N-1. Required response: `in_ready=0`, no `Load`, the word is not accepted, and the current frame is unaffected.
- Idle stall: `bit_stall=1` in IDLE with `in_valid=0` for 10 cycles. Required response: all control outputs stay 0 and `in_ready` stays 1.

Source files
------------

// File: rtl/shift_tx_ctrl.sv
// Parallel-in, serial-out sequencer for a Load/Shift register: accepts a word over
// valid/ready, loads it once, then steps the register one bit per consumed serial bit.
module shift_tx_ctrl #(
    parameter int   N    = 16,
    parameter logic FILL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [N-1:0]         in_data,
    output logic                 in_ready,
    input  logic                 bit_stall,
    output logic                 bit_valid,
    output logic                 Load,
    output logic                 Shift,
    output logic [N-1:0]         Din,
    output logic                 Shift_In,
    output logic [$clog2(N)-1:0] bit_idx,
    output logic                 done
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          consume;
    logic          last_bit;

    assign Din      = in_data;
    assign Shift_In = FILL;
    assign bit_idx  = cnt;

    // Outputs depend on registered state plus same-cycle in_valid/bit_stall, so a
    // finishing frame can hand straight over to the next word without a bubble.
    always_comb begin
        last_bit  = (cnt == LAST_IDX);
        bit_valid = (state == SEND);
        consume   = bit_valid & ~bit_stall;
        in_ready  = (state == IDLE) | (consume & last_bit);
        Load      = in_valid & in_ready;
        Shift     = consume & ~last_bit;
        done      = consume & last_bit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        state <= SEND;
                        cnt   <= '0;
                    end
                end
                SEND: begin
                    if (consume) begin
                        if (last_bit) begin
                            // A new word accepted here restarts the frame at its MSB.
                            state <= Load ? SEND : IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Bench for shift_tx_ctrl: a behavioural register plus a bits-remaining model with a
// queue of expected serial bits, checked every cycle, followed by directed and random traffic.
module tb_shift_tx_ctrl;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;
    logic         bit_stall;
    logic         bit_valid;
    logic         Load;
    logic         Shift;
    logic [N-1:0] Din;
    logic         Shift_In;
    logic [3:0]   bit_idx;
    logic         done;

    shift_tx_ctrl #(.N(N), .FILL(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .bit_stall(bit_stall), .bit_valid(bit_valid),
        .Load(Load), .Shift(Shift), .Din(Din), .Shift_In(Shift_In),
        .bit_idx(bit_idx), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream Load/Shift register that the controller drives.
    logic [N-1:0] tbreg;
    always @(posedge clk) begin
        if (Load)       tbreg <= Din;
        else if (Shift) tbreg <= {tbreg[N-2:0], Shift_In};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Statistics observed from the DUT, used by the directed sequences.
    int           cyc_n = 0;
    int           n_load = 0, n_done = 0, n_shift = 0, n_b2b = 0;
    int           load_cyc = 0, done_cyc = 0;
    int           run = 0, last_run = 0;
    logic [N-1:0] stream = '0;

    // Reference: rem = bits of the current frame still to be consumed (0 means idle).
    int rem = 0;
    bit expq[$];

    initial begin
        bit m_bv, m_cons, m_last, m_rdy, m_acc;
        forever begin
            @(negedge clk);
            m_bv   = (rem > 0);
            m_cons = m_bv && !bit_stall;
            m_last = (rem == 1);
            m_rdy  = (rem == 0) || (m_cons && m_last);
            m_acc  = in_valid && m_rdy;

            check("in_ready",  {31'b0, in_ready},  {31'b0, m_rdy});
            check("bit_valid", {31'b0, bit_valid}, {31'b0, m_bv});
            check("Load",      {31'b0, Load},      {31'b0, m_acc});
            check("Shift",     {31'b0, Shift},     {31'b0, m_cons && !m_last});
            check("done",      {31'b0, done},      {31'b0, m_cons && m_last});
            check("bit_idx",   {28'b0, bit_idx},   (rem > 0) ? 32'(N - rem) : 32'd0);
            check("Din",       {16'b0, Din},       {16'b0, in_data});
            check("Shift_In",  {31'b0, Shift_In},  32'd0);
            if (m_bv && expq.size() > 0)
                check("serial_bit", {31'b0, tbreg[N-1]}, {31'b0, expq[0]});

            if (Load)  begin n_load++; load_cyc = cyc_n; end
            if (done)  begin n_done++; done_cyc = cyc_n; end
            if (Shift) n_shift++;
            if (Load && done) n_b2b++;
            if (bit_valid && !bit_stall) stream = {stream[N-2:0], tbreg[N-1]};
            if (bit_valid) run++;
            else begin
                if (run > 0) last_run = run;
                run = 0;
            end

            if (!reset) begin
                rem = 0;
                expq.delete();
            end else begin
                if (m_cons) begin
                    void'(expq.pop_front());
                    rem--;
                end
                if (m_acc) begin
                    for (int i = N - 1; i >= 0; i--) expq.push_back(in_data[i]);
                    rem = N;
                end
            end
            cyc_n++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int l0, d0, s0, b0;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; bit_stall = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // Single word, no stall.
        s0 = n_shift;
        in_valid = 1'b1; in_data = 16'hA5C3;
        cyc();
        in_valid = 1'b0;
        repeat (16) cyc();
        check("single_stream", {16'b0, stream}, 32'h0000A5C3);
        check("single_done_latency", 32'(done_cyc - load_cyc), 32'd16);
        check("single_shift_count", 32'(n_shift - s0), 32'd15);
        cyc();

        // Back-to-back words with in_valid held high.
        b0 = n_b2b;
        in_valid = 1'b1; in_data = 16'hFFFF;
        cyc();
        in_data = 16'h0001;
        repeat (16) cyc();
        in_valid = 1'b0;
        repeat (16) cyc();
        cyc();
        check("b2b_stream", {16'b0, stream}, 32'h00000001);
        check("b2b_load_on_done", 32'(n_b2b - b0), 32'd1);
        check("b2b_contiguous_valid", 32'(last_run), 32'd32);

        // Three-cycle stall while bit_idx is 2.
        in_valid = 1'b1; in_data = 16'h9A5C;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        bit_stall = 1'b1;
        repeat (3) cyc();
        bit_stall = 1'b0;
        repeat (14) cyc();
        check("stall_stream", {16'b0, stream}, 32'h00009A5C);
        check("stall_done_latency", 32'(done_cyc - load_cyc), 32'd19);
        cyc();

        // Reset mid-frame at bit_idx 5, then a clean word.
        d0 = n_done;
        in_valid = 1'b1; in_data = 16'h5A5A;
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        check("reset_no_done", 32'(n_done - d0), 32'd0);
        in_valid = 1'b1; in_data = 16'h1234;
        cyc();
        in_valid = 1'b0;
        repeat (16) cyc();
        check("post_reset_stream", {16'b0, stream}, 32'h00001234);
        check("post_reset_done", 32'(n_done - d0), 32'd1);

        // in_valid pulsed mid-frame must not be accepted.
        l0 = n_load;
        in_valid = 1'b1; in_data = 16'hC3A5;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        in_valid = 1'b1; in_data = 16'hFFFF;
        cyc();
        in_valid = 1'b0;
        repeat (13) cyc();
        check("handshake_stream", {16'b0, stream}, 32'h0000C3A5);
        check("handshake_one_load", 32'(n_load - l0), 32'd1);

        // Stall in IDLE is ignored.
        l0 = n_load; s0 = n_shift; d0 = n_done;
        bit_stall = 1'b1;
        repeat (10) cyc();
        bit_stall = 1'b0;
        check("idle_stall_load",  32'(n_load - l0),  32'd0);
        check("idle_stall_shift", 32'(n_shift - s0), 32'd0);
        check("idle_stall_done",  32'(n_done - d0),  32'd0);

        // Random traffic with occasional resets.
        repeat (3000) begin
            reset     = ($urandom_range(0, 199) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            bit_stall = ($urandom_range(0, 3) == 0);
            in_data   = 16'($urandom);
            cyc();
        end
        reset = 1'b1; in_valid = 1'b0; bit_stall = 1'b0;
        repeat (20) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
